mux_n_pipe: RTL

- Pipelined, parametrised N:1 multiplexer for W-bit channels, built as a binary select tree of M levels.
- Optional register after every tree level. Valid/ready handshake with full backpressure.
- Out-of-range select flag.
- Drop-in successor to the combinational N:1 mux wherever timing needs a registered, flow-controlled path (datapath channel selection, debug/probe muxing).

---
 rtl/mux_n_pkg.sv | 23 ++
 rtl/mux_n_stage.sv | 66 ++++++
 rtl/mux_n_pipe.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mux_n_pkg.sv
// Elaboration helpers shared by the pipelined N:1 select tree.
package mux_n_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Legal when 2**M covers N; M = 0 is then only reachable with N = 1.
  function automatic bit params_ok(input int unsigned n, input int unsigned m);
    return (n >= 1) && (m <= 30) && (m >= clog2(n));
  endfunction

  // Words left after tree level k of an m-level tree.
  function automatic int unsigned level_words(input int unsigned m, input int unsigned k);
    return (k < m) ? (32'd1 << (m - 1 - k)) : 32'd1;
  endfunction

endpackage

// File: rtl/mux_n_stage.sv
// One select-tree level: pairs words by d_sel[0] and registers the result,
// the remaining select bits, err and valid behind a skid-free advance chain.
module mux_n_stage
  import mux_n_pkg::*;
#(
  parameter int unsigned WORDS_IN = 2,
  parameter int unsigned W        = 8,
  parameter int unsigned SELW     = 1,
  localparam int unsigned WORDS_OUT = (WORDS_IN > 1) ? WORDS_IN / 2 : 1,
  localparam int unsigned SELO      = (WORDS_IN > 1 && SELW > 1) ? SELW - 1 : SELW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORDS_IN*W-1:0]  d_words,
  input  logic [SELW-1:0]        d_sel,
  input  logic                   d_err,
  input  logic                   d_valid,
  input  logic                   adv_next,
  output logic                   adv_c,
  output logic [WORDS_OUT*W-1:0] q_words,
  output logic [SELO-1:0]        q_sel,
  output logic                   q_err,
  output logic                   q_valid
);

  logic [WORDS_OUT*W-1:0] words_c;
  logic [SELO-1:0]        sel_c;

  generate
    if (WORDS_IN > 1) begin : g_pair
      // select bit 1 picks the upper entry of each adjacent pair
      always_comb begin
        words_c = '0;
        for (int unsigned j = 0; j < WORDS_OUT; j++) begin
          words_c[j*W +: W] = d_sel[0] ? d_words[(2*j+1)*W +: W] : d_words[2*j*W +: W];
        end
      end
      if (SELW > 1) begin : g_sel_shift
        assign sel_c = d_sel[SELW-1:1];
      end else begin : g_sel_done
        assign sel_c = '0;
      end
    end else begin : g_pass
      assign words_c = d_words;
      assign sel_c   = d_sel;
    end
  endgenerate

  // An empty stage, or one whose beat leaves this edge, may take a new beat.
  assign adv_c = !q_valid || adv_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_words <= '0;
      q_sel   <= '0;
      q_err   <= 1'b0;
      q_valid <= 1'b0;
    end else if (adv_c) begin
      q_words <= words_c;
      q_sel   <= sel_c;
      q_err   <= d_err;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// Pipelined N:1 multiplexer of W-bit channels: binary select tree of M levels
// with valid/ready flow control and an out-of-range select flag.
module mux_n_pipe
  import mux_n_pkg::*;
#(
  parameter int unsigned N    = 9,
  parameter int unsigned W    = 8,
  parameter int unsigned M    = 4,
  parameter int unsigned PIPE = 1,
  localparam int unsigned SW  = (M > 0) ? M : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N*W-1:0] inp,
  input  logic [SW-1:0] select,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out,
  output logic          out_err,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int unsigned P      = 32'd1 << M;
  localparam bit          BYPASS = (N == 1) || (M == 0);
  localparam bit          NO_PAD = (N == P);

  logic sel_err_c;

  generate
    if (!params_ok(N, M)) begin : g_bad_params
      $error("mux_n_pipe: 2**M must be >= N (N=%0d M=%0d)", N, M);
    end

    // Only padded channels can be out of range; a full or single-channel mux never flags.
    if (BYPASS || NO_PAD) begin : g_no_err
      assign sel_err_c = 1'b0;
    end else begin : g_err
      assign sel_err_c = 32'(select) >= N;
    end

    if (BYPASS) begin : g_slice
      logic [SW-1:0] sel_unused;

      mux_n_stage #(
        .WORDS_IN (1),
        .W        (W),
        .SELW     (SW)
      ) u_stage (
        .clk      (clk),
        .rst      (rst),
        .d_words  (inp[W-1:0]),
        .d_sel    (select),
        .d_err    (sel_err_c),
        .d_valid  (in_valid),
        .adv_next (out_ready),
        .adv_c    (in_ready),
        .q_words  (out),
        .q_sel    (sel_unused),
        .q_err    (out_err),
        .q_valid  (out_valid)
      );
    end else if (PIPE == 0) begin : g_flat
      logic [P*W-1:0] tree_c;
      logic [SW-1:0]  sel_unused;

      // Whole tree folded in place; padded channels are zero so an
      // out-of-range select naturally yields a zero word.
      always_comb begin
        tree_c = '0;
        tree_c[N*W-1:0] = inp;
        for (int unsigned k = 0; k < M; k++) begin
          for (int unsigned j = 0; j < level_words(M, k); j++) begin
            tree_c[j*W +: W] = select[k] ? tree_c[(2*j+1)*W +: W] : tree_c[2*j*W +: W];
          end
        end
      end

      mux_n_stage #(
        .WORDS_IN (1),
        .W        (W),
        .SELW     (SW)
      ) u_stage (
        .clk      (clk),
        .rst      (rst),
        .d_words  (tree_c[W-1:0]),
        .d_sel    (select),
        .d_err    (sel_err_c),
        .d_valid  (in_valid),
        .adv_next (out_ready),
        .adv_c    (in_ready),
        .q_words  (out),
        .q_sel    (sel_unused),
        .q_err    (out_err),
        .q_valid  (out_valid)
      );
    end else begin : g_pipe
      logic [P*W-1:0] padded_c;

      always_comb begin
        padded_c = '0;
        padded_c[N*W-1:0] = inp;
      end

      for (genvar k = 0; k < M; k++) begin : g_lvl
        localparam int unsigned WI  = 2 * level_words(M, k);
        localparam int unsigned SWK = M - k;
        localparam int unsigned SWO = (SWK > 1) ? SWK - 1 : 1;

        logic [WI*W-1:0]   d_words;
        logic [SWK-1:0]    d_sel;
        logic              d_err;
        logic              d_valid;
        logic              adv_next;
        logic              adv_c;
        logic [WI/2*W-1:0] q_words;
        logic [SWO-1:0]    q_sel;
        logic              q_err;
        logic              q_valid;

        if (k == 0) begin : g_head
          assign d_words = padded_c;
          assign d_sel   = select;
          assign d_err   = sel_err_c;
          assign d_valid = in_valid;
        end else begin : g_body
          assign d_words = g_lvl[k-1].q_words;
          assign d_sel   = g_lvl[k-1].q_sel;
          assign d_err   = g_lvl[k-1].q_err;
          assign d_valid = g_lvl[k-1].q_valid;
        end

        // Advance ripples back from out_ready, so in_ready is combinational.
        if (k == M - 1) begin : g_tail
          logic sel_unused;
          assign sel_unused = q_sel[0];
          assign adv_next   = out_ready;
        end else begin : g_mid
          assign adv_next = g_lvl[k+1].adv_c;
        end

        mux_n_stage #(
          .WORDS_IN (WI),
          .W        (W),
          .SELW     (SWK)
        ) u_stage (
          .clk      (clk),
          .rst      (rst),
          .d_words  (d_words),
          .d_sel    (d_sel),
          .d_err    (d_err),
          .d_valid  (d_valid),
          .adv_next (adv_next),
          .adv_c    (adv_c),
          .q_words  (q_words),
          .q_sel    (q_sel),
          .q_err    (q_err),
          .q_valid  (q_valid)
        );
      end

      assign in_ready  = g_lvl[0].adv_c;
      assign out       = g_lvl[M-1].q_words;
      assign out_err   = g_lvl[M-1].q_err;
      assign out_valid = g_lvl[M-1].q_valid;
    end
  endgenerate

endmodule
